// File: rtl/mc.sv
// rtl/mc.sv - arbitrates IC byte fetches and LS multi-byte load/store onto one byte-wide sync RAM.
// Optional store stall on a full IO region is enabled by defining MC_IO_STALL_EN.
module mc #(
    parameter int ADD_W     = 32,
    parameter int RAM_ADD_W = 18
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 iIC_En,
    input  logic [ADD_W-1:0]     iIC_Add,
    output logic                 oIC_En,
    output logic [7:0]           oIC_Dat,
    input  logic                 iLS_En,
    input  logic                 iLS_Wr,
    input  logic [1:0]           iLS_Len,
    input  logic [ADD_W-1:0]     iLS_Add,
    input  logic [31:0]          iLS_Dat,
    output logic                 oLS_En,
    output logic [31:0]          oLS_Dat,
    output logic                 oRAM_Wr,
    output logic [RAM_ADD_W-1:0] oRAM_Add,
    output logic [7:0]           oRAM_Dat,
    input  logic [7:0]           iRAM_Dat
`ifdef MC_IO_STALL_EN
    ,
    input  logic                 iIO_Full
`endif
);
    typedef enum logic [1:0] {IDLE, RD, WR} state_t;

    state_t                 state, state_nx;
    logic                   ic_pend, ls_pend, ls_wr, cur_ls, wr_q, ic_en_q, ls_en_q, v1;
    logic [RAM_ADD_W-1:0]   ic_add, ls_add, cur_add, ram_add_q;
    logic [1:0]             ls_len;
    logic [31:0]            ls_dat, cur_dat, ld_buf, ld_word, ls_dat_q;
    logic [2:0]             cur_n, ai, ci, d1, ci_nx, ai_nx, ai_p1;
    logic [7:0]             ic_dat_q, ram_dat_q;
    logic                   sel_ls, sel_ic, cap, rd_done, wr_last, wr_step, io_stall;
    logic                   unused_add;

    assign unused_add = ^{iIC_Add[ADD_W-1:RAM_ADD_W], iLS_Add[ADD_W-1:RAM_ADD_W]};

`ifdef MC_IO_STALL_EN
    assign io_stall = iIO_Full && (ram_add_q[17:16] == 2'b11);
`else
    assign io_stall = 1'b0;
`endif

    function automatic logic [2:0] len_bytes(input logic [1:0] len);
        case (len)
            2'd0:    return 3'd1;
            2'd1:    return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

    // d1/v1 shadow the RAM pipeline on every clock (even frozen ones): they name the
    // index whose byte is on iRAM_Dat now. A capture only happens when that index is the
    // next lane wanted; otherwise the wanted address is re-presented, which recovers after en=0.
    always_comb begin
        state_nx = state;
        sel_ls   = (state == IDLE) && ls_pend;
        sel_ic   = (state == IDLE) && !ls_pend && ic_pend;
        cap      = (state == RD) && v1 && (d1 == ci);
        ci_nx    = ci + {2'b00, cap};
        rd_done  = cap && (ci_nx == cur_n);
        ai_p1    = ai + 3'd1;
        ai_nx    = ci_nx;
        if (ai == ci_nx)
            ai_nx = (ai_p1 < cur_n) ? ai_p1 : ai;
        wr_last  = (ai_p1 == cur_n);
        wr_step  = (state == WR) && !io_stall;
        ld_word  = ld_buf;
        ld_word[{ci[1:0], 3'b000} +: 8] = iRAM_Dat;
        case (state)
            IDLE: begin
                if (sel_ls)      state_nx = ls_wr ? WR : RD;
                else if (sel_ic) state_nx = RD;
            end
            RD:      if (rd_done) state_nx = IDLE;
            WR:      if (wr_step && wr_last) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)     state <= IDLE;
        else if (en)  state <= state_nx;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ic_pend <= 1'b0; ls_pend <= 1'b0; ls_wr <= 1'b0; cur_ls <= 1'b0;
            wr_q <= 1'b0; ic_en_q <= 1'b0; ls_en_q <= 1'b0; v1 <= 1'b0;
            ic_add <= '0; ls_add <= '0; cur_add <= '0; ram_add_q <= '0;
            ls_len <= 2'd0; ls_dat <= '0; cur_dat <= '0; ld_buf <= '0; ls_dat_q <= '0;
            cur_n <= 3'd0; ai <= 3'd0; ci <= 3'd0; d1 <= 3'd0;
            ic_dat_q <= 8'd0; ram_dat_q <= 8'd0;
        end else begin
            v1 <= (state == RD);
            d1 <= ai;
            if (en) begin
                ic_en_q <= 1'b0;
                ls_en_q <= 1'b0;
                if (sel_ic) ic_pend <= 1'b0;
                else if (iIC_En && !ic_pend) begin
                    ic_pend <= 1'b1;
                    ic_add  <= iIC_Add[RAM_ADD_W-1:0];
                end
                if (sel_ls) ls_pend <= 1'b0;
                else if (iLS_En && !ls_pend) begin
                    ls_pend <= 1'b1;
                    ls_wr   <= iLS_Wr;
                    ls_len  <= iLS_Len;
                    ls_add  <= iLS_Add[RAM_ADD_W-1:0];
                    ls_dat  <= iLS_Dat;
                end
                if (sel_ls || sel_ic) begin
                    ai        <= 3'd0;
                    ci        <= 3'd0;
                    ld_buf    <= '0;
                    cur_ls    <= sel_ls;
                    cur_add   <= sel_ls ? ls_add : ic_add;
                    ram_add_q <= sel_ls ? ls_add : ic_add;
                    cur_n     <= sel_ls ? len_bytes(ls_len) : 3'd1;
                    cur_dat   <= ls_dat;
                    if (sel_ls && ls_wr) begin
                        wr_q      <= 1'b1;
                        ram_dat_q <= ls_dat[7:0];
                    end
                end
                if (state == RD) begin
                    ci <= ci_nx;
                    if (cap) ld_buf[{ci[1:0], 3'b000} +: 8] <= iRAM_Dat;
                    if (rd_done) begin
                        if (cur_ls) begin
                            ls_en_q  <= 1'b1;
                            ls_dat_q <= ld_word;
                        end else begin
                            ic_en_q  <= 1'b1;
                            ic_dat_q <= iRAM_Dat;
                        end
                    end else begin
                        ai        <= ai_nx;
                        ram_add_q <= cur_add + RAM_ADD_W'(ai_nx);
                    end
                end
                if (wr_step) begin
                    if (wr_last) begin
                        wr_q    <= 1'b0;
                        ls_en_q <= 1'b1;
                    end else begin
                        ai        <= ai_p1;
                        ram_add_q <= cur_add + RAM_ADD_W'(ai_p1);
                        ram_dat_q <= cur_dat[{ai_p1[1:0], 3'b000} +: 8];
                    end
                end
            end
        end
    end

    assign oIC_En   = ic_en_q;
    assign oIC_Dat  = ic_dat_q;
    assign oLS_En   = ls_en_q;
    assign oLS_Dat  = ls_dat_q;
    assign oRAM_Wr  = wr_q && en && !io_stall;
    assign oRAM_Add = ram_add_q;
    assign oRAM_Dat = ram_dat_q;
endmodule

// File: tb/tb_mc.sv
// tb/tb_mc.sv - randomized scoreboard bench for mc with a behavioural RAM/load-store reference model.
module tb_mc;
    localparam int MASK = 'h3FFFF;

    typedef struct packed {
        logic        st;
        logic [31:0] d;
    } ls_exp_t;

    logic        clk, rst, en, iIC_En, iLS_En, iLS_Wr, oIC_En, oLS_En, oRAM_Wr, io_full;
    logic [31:0] iIC_Add, iLS_Add, iLS_Dat, oLS_Dat;
    logic [1:0]  iLS_Len;
    logic [7:0]  oIC_Dat, oRAM_Dat, ram_q;
    logic [17:0] oRAM_Add;

    logic [7:0]  mem     [0:MASK];
    logic [7:0]  ref_mem [0:MASK];
    logic [7:0]  icq[$];
    ls_exp_t     lsq[$];
    logic [31:0] exp_hold;
    int          n_vec, n_err, cyc, ic_t, ls_t;
    logic        prev_ic, prev_ls;

    mc dut (
        .clk(clk), .rst(rst), .en(en),
        .iIC_En(iIC_En), .iIC_Add(iIC_Add), .oIC_En(oIC_En), .oIC_Dat(oIC_Dat),
        .iLS_En(iLS_En), .iLS_Wr(iLS_Wr), .iLS_Len(iLS_Len), .iLS_Add(iLS_Add),
        .iLS_Dat(iLS_Dat), .oLS_En(oLS_En), .oLS_Dat(oLS_Dat),
        .oRAM_Wr(oRAM_Wr), .oRAM_Add(oRAM_Add), .oRAM_Dat(oRAM_Dat), .iRAM_Dat(ram_q)
`ifdef MC_IO_STALL_EN
        ,
        .iIO_Full(io_full)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc++;
        if (oRAM_Wr) mem[oRAM_Add] <= oRAM_Dat;
        ram_q <= mem[oRAM_Add];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            if (oIC_En || oLS_En) chk("pulse_excl", {31'd0, oIC_En & oLS_En}, 32'd0);
            if (oIC_En && !prev_ic) begin
                ic_t = cyc;
                if (icq.size() == 0) chk("ic_unexpected", 32'd1, 32'd0);
                else chk("ic_dat", {24'd0, oIC_Dat}, {24'd0, icq.pop_front()});
            end
            if (oLS_En && !prev_ls) begin
                ls_exp_t e;
                ls_t = cyc;
                if (lsq.size() == 0) chk("ls_unexpected", 32'd1, 32'd0);
                else begin
                    e = lsq.pop_front();
                    chk(e.st ? "ls_store_hold" : "ls_load", oLS_Dat, e.d);
                end
            end
        end
        prev_ic = oIC_En;
        prev_ls = oLS_En;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic setb(input int a, input logic [7:0] v);
        mem[a & MASK]     = v;
        ref_mem[a & MASK] = v;
    endtask

    function automatic logic [31:0] ref_load(input int a, input int n);
        logic [31:0] r = 32'd0;
        for (int k = 0; k < n; k++) r |= 32'(ref_mem[(a + k) & MASK]) << (8 * k);
        return r;
    endfunction

    task automatic issue(input bit do_ic, input int ic_a, input bit do_ls, input bit wr,
                         input int len, input int ls_a, input logic [31:0] d);
        int n;
        n = (len == 0) ? 1 : (len == 1) ? 2 : 4;
        if (do_ic) begin
            icq.push_back(ref_mem[ic_a & MASK]);
            iIC_En = 1'b1;
            iIC_Add = ic_a;
        end
        if (do_ls) begin
            if (wr) begin
                for (int k = 0; k < n; k++) ref_mem[(ls_a + k) & MASK] = 8'(d >> (8 * k));
                lsq.push_back({1'b1, exp_hold});
            end else begin
                exp_hold = ref_load(ls_a, n);
                lsq.push_back({1'b0, exp_hold});
            end
            iLS_En = 1'b1; iLS_Wr = wr; iLS_Len = 2'(len); iLS_Add = ls_a; iLS_Dat = d;
        end
        en = 1'b1;
        tick();
        iIC_En = 1'b0;
        iLS_En = 1'b0;
    endtask

    task automatic wait_done(input bit rnd);
        int k = 0;
        while ((icq.size() != 0 || lsq.size() != 0) && k < 400) begin
            if (rnd && $urandom_range(0, 7) == 0) begin
                en = 1'b0;
                repeat ($urandom_range(1, 3)) tick();
                en = 1'b1;
            end
            tick();
            k++;
        end
        if (icq.size() != 0 || lsq.size() != 0) begin
            chk("timeout_outstanding", 32'(icq.size() + lsq.size()), 32'd0);
            icq.delete();
            lsq.delete();
        end
        tick();
        tick();
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ic"}, {23'd0, oIC_En, oIC_Dat}, 32'd0);
        chk({tag, "_ls_en"}, {31'd0, oLS_En}, 32'd0);
        chk({tag, "_ls_dat"}, oLS_Dat, 32'd0);
        chk({tag, "_ram"}, {5'd0, oRAM_Wr, oRAM_Add, oRAM_Dat}, 32'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bit seen_wrap;
        int errs;
        n_vec = 0; n_err = 0; cyc = 0; ic_t = 0; ls_t = 0; exp_hold = 32'd0;
        prev_ic = 1'b0; prev_ls = 1'b0;
        rst = 1'b0; en = 1'b1; io_full = 1'b0;
        iIC_En = 1'b0; iIC_Add = '0; iLS_En = 1'b0; iLS_Wr = 1'b0; iLS_Len = '0;
        iLS_Add = '0; iLS_Dat = '0;
        for (int i = 0; i <= MASK; i++) setb(i, 8'($urandom));

        repeat (3) tick();
        chk_all_zero("reset");
        rst = 1'b1;
        tick();
        chk_all_zero("post_reset");

        // IC fetch: address one cycle after latch, data two cycles after selection
        setb('h100, 8'hAB);
        issue(1, 'h100, 0, 0, 0, 0, 0);
        tick(); chk("ic_add", 32'(oRAM_Add), 32'h100);
        tick();
        tick(); chk("ic_pulse", {23'd0, oIC_En, oIC_Dat}, {23'd0, 1'b1, 8'hAB});
        tick(); chk("ic_pulse_end", {31'd0, oIC_En}, 32'd0);
        wait_done(0);

        // 4-byte load with per-cycle address stepping
        setb('h200, 8'h11); setb('h201, 8'h22); setb('h202, 8'h33); setb('h203, 8'h44);
        issue(0, 0, 1, 0, 2, 'h200, 0);
        for (int k = 0; k < 4; k++) begin
            tick(); chk("ld_add", 32'(oRAM_Add), 32'h200 + 32'(k));
        end
        tick(); chk("ld_early", {31'd0, oLS_En}, 32'd0);
        tick(); chk("ld_word", {oLS_Dat[31:1], oLS_En}, {31'h22199108, 1'b1});
        chk("ld_word_full", oLS_Dat, 32'h44332211);
        wait_done(0);

        // 2-byte store, then read it back
        issue(0, 0, 1, 1, 1, 'h10, 32'h1234);
        tick(); chk("st_b0", {6'd0, oRAM_Wr, oRAM_Add, oRAM_Dat}, {6'd0, 1'b1, 18'h10, 8'h34});
        tick(); chk("st_b1", {6'd0, oRAM_Wr, oRAM_Add, oRAM_Dat}, {6'd0, 1'b1, 18'h11, 8'h12});
        tick(); chk("st_done", {30'd0, oLS_En, oRAM_Wr}, {30'd0, 1'b1, 1'b0});
        wait_done(0);
        chk("st_mem", {16'd0, mem['h11], mem['h10]}, 32'h1234);
        issue(0, 0, 1, 0, 1, 'h10, 0);
        wait_done(0);
        chk("st_readback", oLS_Dat, 32'h00001234);

        // simultaneous IC + LS: LS first
        ic_t = 0; ls_t = 0;
        issue(1, 0, 1, 0, 2, 0, 0);
        wait_done(0);
        chk("arb_ls_first", {31'd0, (ic_t > ls_t) && (ls_t != 0)}, 32'd1);

        // second IC request while one is pending is dropped
        issue(0, 0, 1, 0, 2, 'h40, 0);
        issue(1, 'h80, 0, 0, 0, 0, 0);
        iIC_En = 1'b1; iIC_Add = 'h90;
        tick();
        iIC_En = 1'b0;
        wait_done(0);
        repeat (8) tick();

        // en freeze mid 4-byte load across the address wrap
        issue(0, 0, 1, 0, 2, 'h3FFFE, 0);
        tick(); chk("fz_a0", 32'(oRAM_Add), 32'h3FFFE);
        tick(); chk("fz_a1", 32'(oRAM_Add), 32'h3FFFF);
        en = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("fz_hold", {13'd0, oLS_En, oRAM_Add}, {13'd0, 1'b0, 18'h3FFFF});
        end
        en = 1'b1;
        seen_wrap = 1'b0;
        for (int k = 0; k < 20 && lsq.size() != 0; k++) begin
            tick();
            if (oRAM_Add == 18'h0) seen_wrap = 1'b1;
        end
        chk("fz_wrap_seen", {31'd0, seen_wrap}, 32'd1);
        wait_done(0);

        // reset mid-store: data equals current contents so partial writes leave memory intact
        iLS_En = 1'b1; iLS_Wr = 1'b1; iLS_Len = 2'd2; iLS_Add = 'h500;
        iLS_Dat = ref_load('h500, 4);
        tick();
        iLS_En = 1'b0;
        tick();
        tick(); chk("rst_mid_wr", {31'd0, oRAM_Wr}, 32'd1);
        rst = 1'b0;
        #1;
        chk_all_zero("rst_mid");
        exp_hold = 32'd0;
        tick(); tick();
        rst = 1'b1;
        repeat (3) tick();
        chk("rst_no_resp", {30'd0, oLS_En, oRAM_Wr}, 32'd0);

`ifdef MC_IO_STALL_EN
        io_full = 1'b1;
        issue(0, 0, 1, 1, 0, 'h30000, 32'h5A);
        tick(); chk("io_stall0", {13'd0, oRAM_Wr, oRAM_Add}, {13'd0, 1'b0, 18'h30000});
        for (int k = 0; k < 3; k++) begin
            tick(); chk("io_stall", {31'd0, oRAM_Wr}, 32'd0);
        end
        io_full = 1'b0;
        #1; chk("io_resume_wr", {31'd0, oRAM_Wr}, 32'd1);
        tick(); chk("io_done", {30'd0, oLS_En, oRAM_Wr}, {30'd0, 1'b1, 1'b0});
        chk("io_mem", {24'd0, mem['h30000]}, 32'h5A);
        wait_done(0);
`endif

        for (int t = 0; t < 80; t++) begin
            int kind, base, a, b;
            kind = $urandom_range(0, 3);
            base = ($urandom_range(0, 2) == 0) ? 0 : ($urandom_range(0, 1) == 0) ? 'h3FFF0 : 'h2000;
            a = base + $urandom_range(0, 15);
            b = base + $urandom_range(0, 15);
            case (kind)
                0: issue(1, a, 0, 0, 0, 0, 0);
                1: issue(0, 0, 1, 0, $urandom_range(0, 3), a, 0);
                2: issue(0, 0, 1, 1, $urandom_range(0, 3), a, $urandom);
                default: issue(1, b, 1, 0, $urandom_range(0, 3), a, 0);
            endcase
            wait_done(1);
        end

        errs = 0;
        for (int i = 0; i < 32; i++) begin
            if (mem[i] !== ref_mem[i]) errs++;
            if (mem['h2000 + i] !== ref_mem['h2000 + i]) errs++;
            if (mem[('h3FFF0 + i) & MASK] !== ref_mem[('h3FFF0 + i) & MASK]) errs++;
        end
        chk("mem_final", 32'(errs), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
